// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for one pipeline stage boundary.
// Upstream (in_*) and downstream (out_*) sides are both seen from the stage.
interface pipe_stage_reg_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               in_pred_taken;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_pred_taken;

  // Environment side: produces upstream words and downstream ready.
  modport master (
    output in_valid, in_instr, in_pc, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pred_taken
  );

  // Stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, in_pred_taken, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pred_taken
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// IF/ID-class stage register: main + skid entry, stall/flush control,
// NOP bubble when empty, saturating count of squashed entries.
module pipe_stage_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  pipe_stage_reg_if.slave     bus,
  input  logic                stall,
  input  logic                flush,
  output logic [CNT_W-1:0]    squash_count
);

  logic               main_valid;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    main_pc;
  logic               main_pred;

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               skid_pred;

  logic               accept;
  logic               consume;
  logic [CNT_W:0]     squash_sum;

  always_comb begin
    accept     = bus.in_valid & ~skid_valid & ~flush;
    consume    = main_valid & bus.out_ready & ~stall;
    squash_sum = {1'b0, squash_count} + (CNT_W+1)'(main_valid) + (CNT_W+1)'(skid_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid   <= 1'b0;
      main_instr   <= NOP_INSTR;
      main_pc      <= '0;
      main_pred    <= 1'b0;
      skid_valid   <= 1'b0;
      skid_instr   <= NOP_INSTR;
      skid_pc      <= '0;
      skid_pred    <= 1'b0;
      squash_count <= '0;
    end else if (flush) begin
      main_valid   <= 1'b0;
      main_instr   <= NOP_INSTR;
      main_pc      <= '0;
      main_pred    <= 1'b0;
      skid_valid   <= 1'b0;
      squash_count <= squash_sum[CNT_W] ? '1 : squash_sum[CNT_W-1:0];
    end else if (!main_valid || consume) begin
      // Skid drains first so a newer word never overtakes it.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
        main_pred  <= skid_pred;
        skid_valid <= accept;
        if (accept) begin
          skid_instr <= bus.in_instr;
          skid_pc    <= bus.in_pc;
          skid_pred  <= bus.in_pred_taken;
        end
      end else if (accept) begin
        main_valid <= 1'b1;
        main_instr <= bus.in_instr;
        main_pc    <= bus.in_pc;
        main_pred  <= bus.in_pred_taken;
      end else begin
        main_valid <= 1'b0;
        main_instr <= NOP_INSTR;
        main_pc    <= '0;
        main_pred  <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_instr <= bus.in_instr;
      skid_pc    <= bus.in_pc;
      skid_pred  <= bus.in_pred_taken;
    end
  end

  assign bus.in_ready       = ~skid_valid;
  assign bus.out_valid      = main_valid;
  assign bus.out_instr      = main_instr;
  assign bus.out_pc         = main_pc;
  assign bus.out_pred_taken = main_pred;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, checked
// against a depth-2 FIFO model; a CNT_W=2 copy shares stimulus for saturation.
module tb_pipe_stage_reg;

  localparam int          INSTR_W = 32;
  localparam int          PC_W    = 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pt;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [15:0] sq;
  logic [1:0]  sq_s;

  pipe_stage_reg_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) bus ();
  pipe_stage_reg_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) bus_s ();

  assign bus_s.in_valid      = bus.in_valid;
  assign bus_s.in_instr      = bus.in_instr;
  assign bus_s.in_pc         = bus.in_pc;
  assign bus_s.in_pred_taken = bus.in_pred_taken;
  assign bus_s.out_ready     = bus.out_ready;

  pipe_stage_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .stall(stall), .flush(flush), .squash_count(sq)
  );

  pipe_stage_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_s.slave), .stall(stall), .flush(flush), .squash_count(sq_s)
  );

  always #5 clk = ~clk;

  ent_t    q[$];
  longint  cnt = 0;
  int      errors = 0;
  int      checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic        v;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        et;
    v  = q.size() > 0;
    ei = v ? q[0].instr : NOP;
    ep = v ? q[0].pc : 32'h0;
    et = v ? q[0].pt : 1'b0;
    check("out_valid", bus.out_valid, v);
    check("out_instr", bus.out_instr, ei);
    check("out_pc", bus.out_pc, ep);
    check("out_pred_taken", bus.out_pred_taken, et);
    check("in_ready", bus.in_ready, q.size() < 2);
    check("squash_count", sq, (cnt > 65535) ? 65535 : cnt);
    check("sat_squash_count", sq_s, (cnt > 3) ? 3 : cnt);
    check("sat_out_instr", bus_s.out_instr, ei);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(input logic rst, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc, input logic pt, input logic ordy,
                      input logic stl, input logic fl);
    bit   acc;
    bit   con;
    ent_t e;
    reset = rst; flush = fl; stall = stl;
    bus.in_valid = iv; bus.in_instr = ins; bus.in_pc = pc;
    bus.in_pred_taken = pt; bus.out_ready = ordy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt = 0;
    end else if (fl) begin
      cnt += q.size();
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      con = (q.size() > 0) && ordy && !stl;
      if (con) void'(q.pop_front());
      if (acc) begin
        e.instr = ins; e.pc = pc; e.pt = pt;
        q.push_back(e);
      end
    end
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [31:0] ins, input logic ordy);
    step(1'b0, 1'b1, ins, ins << 2, ins[0], ordy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.in_pred_taken = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);

    do_reset();
    do_reset();
    check("reset_out_instr", bus.out_instr, NOP);
    check("reset_in_ready", bus.in_ready, 1'b1);

    // Streaming at full rate
    feed(32'h11, 1'b1);
    feed(32'h22, 1'b1);
    feed(32'h33, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure, upstream holds 0x33 until accepted
    feed(32'h11, 1'b0);
    feed(32'h22, 1'b0);
    check("bp_in_ready", bus.in_ready, 1'b0);
    feed(32'h33, 1'b0);
    for (int i = 0; i < 4 && q.size() == 2; i++) feed(32'h33, 1'b1);
    feed(32'h33, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush with both entries full and a word incoming
    do_reset();
    feed(32'hA, 1'b0);
    feed(32'hB, 1'b0);
    step(1'b0, 1'b1, 32'hC, 32'h30, 1'b1, 1'b1, 1'b0, 1'b1);
    check("flush_count", sq, 16'd2);
    check("flush_out_instr", bus.out_instr, NOP);
    idle(1'b1);
    idle(1'b1);

    // Stall holds the main entry
    feed(32'h44, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("stall_hold", bus.out_instr, 32'h44);
    idle(1'b1);
    idle(1'b1);

    // Saturation on the narrow counter
    do_reset();
    for (int i = 0; i < 4; i++) begin
      feed(32'h50 + 32'(i), 1'b0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("sat_final", sq_s, 2'd3);
    check("wide_final", sq, 16'd4);

    // Reset wins over a simultaneous flush
    feed(32'h61, 1'b0);
    feed(32'h62, 1'b0);
    step(1'b1, 1'b1, 32'h63, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_flush_count", sq, 16'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0),
           ($urandom_range(99) < 70),
           $urandom, $urandom, 1'($urandom),
           ($urandom_range(99) < 60),
           ($urandom_range(99) < 15),
           ($urandom_range(99) < 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised IF/ID-class pipeline stage register with valid/ready handshake on both sides and a 2-entry skid buffer (main + skid). It carries instruction, PC and a predicted-taken bit. Hazard-unit stall and branch-resolve flush inputs are supported. It presents a NOP bubble whenever empty or flushed, and counts discarded (squashed) instructions for performance monitoring. It sits between fetch and decode and is reusable at any stage boundary by changing widths.

Parameters:
INSTR_W, 32, instruction field width
PC_W, 32, PC field width
NOP_INSTR, 32'h0000_0000 (INSTR_W bits), value driven on out_instr when no valid entry
CNT_W, 16, width of squash counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
in_valid  input  1  upstream word present
in_ready  output  1  stage can accept this cycle
in_instr  input  INSTR_W  incoming instruction
in_pc  input  PC_W  incoming PC
in_pred_taken  input  1  incoming predicted-taken flag
out_valid  output  1  main entry valid
out_ready  input  1  downstream consumes
out_instr  output  INSTR_W  main instruction, NOP_INSTR when invalid
out_pc  output  PC_W  main PC, 0 when invalid
out_pred_taken  output  1  main flag, 0 when invalid
stall  input  1  hazard hold; forces consume=0
flush  input  1  squash all held and incoming words
squash_count  output  CNT_W  saturating count of discarded valid entries

Behaviour:
- All outputs are registered. Reset (sync): main_valid=0, skid_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pred_taken=0, squash_count=0. in_ready=1 on the cycle after reset.
- in_ready = !skid_valid (registered state only, no combinational path from out_ready).
- accept = in_valid & in_ready & !flush; consume = main_valid & out_ready & !stall.
- Latency 1 cycle from accept into an empty stage to out_valid=1. Sustained throughput 1 word/cycle when consume is held high.
- Next-state without flush:
  - If main empty or consumed:
    - main <= skid if skid_valid, and skid clears; if accept in the same cycle, the incoming word goes to skid.
    - Else main <= incoming if accept.
    - Else main goes invalid and loads NOP_INSTR, PC 0, flag 0.
  - If main valid and not consumed: an accepted word goes to skid. Accept cannot occur while skid_valid, because in_ready=0.
- Ordering is strictly FIFO: skid is never bypassed by a newer word.
- Flush has top priority over accept, consume and stall:
  - Next cycle: main_valid=0, skid_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pred_taken=0.
  - The incoming word is dropped and not counted.
  - squash_count += main_valid + skid_valid, saturating at 2^CNT_W-1 with no wrap.
- Stall with main valid: outputs hold unchanged. One more word may still be accepted into skid; after that in_ready=0.
- Flush and stall asserted together: flush wins.
- Reset asserted together with flush: reset wins, and the count stays 0.
- squash_count changes only on flush or reset.

Test Plan:
- Reset then stream: in_valid=1 with instr 0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_instr 0x11,0x22,0x33 one cycle later each, out_valid continuous, in_ready stays 1.
- Backpressure: out_ready=0 while feeding 0x11,0x22 → main=0x11, skid=0x22, in_ready=0 and 0x33 held upstream. Raise out_ready → outputs 0x11,0x22,0x33 in order, none lost or duplicated.
- Flush with both entries full (main 0xA, skid 0xB) and in_valid=1 with 0xC → next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1, squash_count=2. 0xC never appears.
- Stall=1 for 3 cycles with main=0x44 and out_ready=1 → out_instr stays 0x44 with out_valid=1. Deassert stall → 0x44 consumed exactly once.
- Saturation with CNT_W=2: four flushes each dropping 1 entry → squash_count 1,2,3,3.
- Reset mid-operation with skid full and flush=1 in the same cycle → all state cleared, squash_count=0, out_instr=NOP_INSTR.
